// File: rtl/pin_lockout.sv
// Attempt limiter in front of a PIN checker: gates submits, counts failed
// attempts, imposes timed lockouts and latches a permanent block with alarm.
module pin_lockout #(
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned LOCK_CYCLES  = 16,
  parameter int unsigned MAX_LOCKOUTS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       submit_in,
  input  logic       correct,
  input  logic       incorrect,
  output logic       submit_out,
  output logic       granted,
  output logic       locked,
  output logic       alarm,
  output logic [1:0] tries_left,
  output logic [7:0] lock_remaining
);

  localparam int unsigned TRIES_W = 2;
  localparam int unsigned REM_W   = 8;
  localparam int unsigned LKO_W   = 2;

  localparam logic [TRIES_W-1:0] TRIES_INIT = TRIES_W'(MAX_TRIES);
  localparam logic [REM_W-1:0]   LOCK_INIT  = REM_W'(LOCK_CYCLES);
  localparam logic [LKO_W-1:0]   LKO_LIMIT  = LKO_W'(MAX_LOCKOUTS);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    GRANTED = 2'd1,
    LOCKED  = 2'd2,
    BLOCKED = 2'd3
  } state_t;

  state_t             state;
  logic               primed;
  logic               cor_q;
  logic               inc_q;
  logic [LKO_W-1:0]   lockouts;
  logic               cor_rise;
  logic               inc_rise;
  logic [LKO_W-1:0]   lockouts_inc;

  // primed stays low for the first edge after reset so inputs already high
  // at release are captured into the edge registers without firing.
  assign cor_rise     = primed & correct & ~cor_q;
  assign inc_rise     = primed & incorrect & ~inc_q;
  assign lockouts_inc = lockouts + LKO_W'(1);

  assign submit_out = submit_in & (state == ARMED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ARMED;
      primed         <= 1'b0;
      cor_q          <= 1'b0;
      inc_q          <= 1'b0;
      lockouts       <= '0;
      granted        <= 1'b0;
      locked         <= 1'b0;
      alarm          <= 1'b0;
      tries_left     <= TRIES_INIT;
      lock_remaining <= '0;
    end else begin
      primed <= 1'b1;
      cor_q  <= correct;
      inc_q  <= incorrect;

      case (state)
        ARMED: begin
          // Failure wins over a simultaneous success.
          if (inc_rise) begin
            if (tries_left <= TRIES_W'(1)) begin
              lockouts <= lockouts_inc;
              locked   <= 1'b1;
              if (lockouts_inc == LKO_LIMIT) begin
                state          <= BLOCKED;
                alarm          <= 1'b1;
                tries_left     <= '0;
                lock_remaining <= '0;
              end else begin
                state          <= LOCKED;
                lock_remaining <= LOCK_INIT;
              end
            end else begin
              tries_left <= tries_left - TRIES_W'(1);
            end
          end else if (cor_rise) begin
            state      <= GRANTED;
            granted    <= 1'b1;
            tries_left <= TRIES_INIT;
            lockouts   <= '0;
          end
        end

        GRANTED: begin
          if (submit_in) begin
            state   <= ARMED;
            granted <= 1'b0;
          end
        end

        LOCKED: begin
          if (lock_remaining <= REM_W'(1)) begin
            state          <= ARMED;
            locked         <= 1'b0;
            lock_remaining <= '0;
            tries_left     <= TRIES_INIT;
          end else begin
            lock_remaining <= lock_remaining - REM_W'(1);
          end
        end

        BLOCKED: begin
          locked         <= 1'b1;
          alarm          <= 1'b1;
          tries_left     <= '0;
          lock_remaining <= '0;
        end

        default: begin
          state <= ARMED;
        end
      endcase
    end
  end

endmodule

// File: doc/pin_lockout.md
PIN_LOCKOUT -- requirements
Module: pin_lockout

Interface
REQ-001 The block SHALL have parameter MAX_TRIES, default 3: failed attempts allowed before a lockout, legal range 1..3.
REQ-002 The block SHALL have parameter LOCK_CYCLES, default 16: lockout duration in clk cycles, legal range 1..255.
REQ-003 The block SHALL have parameter MAX_LOCKOUTS, default 2: lockouts allowed before permanent block, legal range 1..3.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port submit_in, input, 1 bit: raw user submit request.
REQ-007 The block SHALL have port correct, input, 1 bit: correct-PIN result from the downstream PIN checker, level.
REQ-008 The block SHALL have port incorrect, input, 1 bit: incorrect-PIN result from the PIN checker, level.
REQ-009 The block SHALL have port submit_out, output, 1 bit: gated submit driven to the PIN checker's submit input.
REQ-010 The block SHALL have port granted, output, 1 bit: access-granted indication.
REQ-011 The block SHALL have port locked, output, 1 bit: entry disabled, either temporary or permanent.
REQ-012 The block SHALL have port alarm, output, 1 bit: permanent block reached.
REQ-013 The block SHALL have port tries_left, output, 2 bits: remaining attempts in the current window.
REQ-014 The block SHALL have port lock_remaining, output, 8 bits: remaining lockout cycles.

Function
REQ-015 The block SHALL register correct and incorrect once and act only on rising edges (cor_rise, inc_rise); a held level SHALL count once.
REQ-016 The FSM SHALL have exactly four states: ARMED, GRANTED, LOCKED, BLOCKED.
REQ-017 submit_out SHALL be combinational submit_in AND (state==ARMED), with zero-cycle latency; it SHALL be 0 in all other states.
REQ-018 In ARMED, cor_rise SHALL move to GRANTED, reload tries_left=MAX_TRIES, and clear the lockout counter.
REQ-019 In ARMED, inc_rise SHALL decrement tries_left; if tries_left was 1, the FSM SHALL instead increment the lockout counter and go to LOCKED, loading lock_remaining=LOCK_CYCLES.
REQ-020 If the incremented lockout counter equals MAX_LOCKOUTS, the FSM SHALL go to BLOCKED instead of LOCKED.
REQ-021 A simultaneous cor_rise and inc_rise SHALL be treated as inc_rise only (fail-safe).
REQ-022 In LOCKED, lock_remaining SHALL decrement by 1 each cycle; on the edge where it is 1, the FSM SHALL go to ARMED with lock_remaining=0 and tries_left=MAX_TRIES; locked SHALL be high for exactly LOCK_CYCLES cycles.
REQ-023 In LOCKED, all edges on correct, incorrect and submit_in SHALL be ignored; edge registers SHALL still track the inputs.
REQ-024 In GRANTED, granted SHALL be 1; submit_in=1 SHALL return the FSM to ARMED next cycle, and that request SHALL NOT be forwarded.
REQ-025 BLOCKED SHALL be terminal until reset, with locked=1, alarm=1, submit_out=0, tries_left=0, lock_remaining=0.
REQ-026 All outputs except submit_out SHALL be registered or decoded from registered state only.
REQ-027 tries_left SHALL never underflow below 0 nor exceed MAX_TRIES.

Reset
REQ-028 Reset low SHALL immediately, and mid-operation in any state, force: ARMED, tries_left=MAX_TRIES, lock_remaining=0, lockout counter=0, edge registers=0, granted=0, locked=0, alarm=0.
REQ-029 Release of reset SHALL take effect on the next rising clk edge; no edge SHALL be detected from inputs already high at release until they fall and rise again.

Verification
REQ-030 The bench SHALL cover: reset, then one correct pulse -> granted=1 next cycle, tries_left=3; submit_in=1 -> ARMED, submit_out stays 0.
REQ-031 The bench SHALL cover: three incorrect pulses -> tries_left 3,2,1, then locked=1, lock_remaining=16; locked stays high for exactly 16 cycles, then ARMED with tries_left=3.
REQ-032 The bench SHALL cover: second lockout (six total incorrect pulses, no correct) -> alarm=1, locked=1 permanently; a correct pulse and submit_in are ignored.
REQ-033 The bench SHALL cover: incorrect held high for 10 cycles -> tries_left decrements by exactly 1.
REQ-034 The bench SHALL cover: correct and incorrect rising on the same cycle -> tries_left decrements and granted stays 0.
REQ-035 The bench SHALL cover: reset asserted at lock_remaining=7 -> immediately ARMED, locked=0, tries_left=3, lockout counter cleared (verified by requiring two further full lockouts to reach alarm).
